// File: rtl/peridot_rx_bytes2packets.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | peridot_rx_bytes2packets: byte-escape framing decoder feeding a          |
// | show-ahead packet FIFO.                                 Revision: 1.0    |
// +--------------------------------------------------------------------------+
module peridot_rx_bytes2packets #(
  parameter int FIFO_DEPTH_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [7:0]                out_data,
  output logic [7:0]                out_channel,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic                      overflow,
  output logic [FIFO_DEPTH_WIDTH:0] fifo_level
);

  localparam int                      DEPTH       = 1 << FIFO_DEPTH_WIDTH;
  localparam logic [FIFO_DEPTH_WIDTH:0] C_DEPTH   = (FIFO_DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [7:0]              C_SOP_BYTE  = 8'h7A;
  localparam logic [7:0]              C_EOP_BYTE  = 8'h7B;
  localparam logic [7:0]              C_CHAN_BYTE = 8'h7C;
  localparam logic [7:0]              C_ESC_BYTE  = 8'h7D;

  logic                        sop_pend_q, sop_pend_d;
  logic                        eop_pend_q, eop_pend_d;
  logic                        esc_pend_q, esc_pend_d;
  logic                        chan_pend_q, chan_pend_d;
  logic [7:0]                  channel_q, channel_d;
  logic                        overflow_q, overflow_d;
  logic [FIFO_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_WIDTH:0]   level_q, level_d;
  logic [17:0]                 mem_q [DEPTH];

  logic [7:0]  w_literal;
  logic        w_is_literal;
  logic        w_wr_req;
  logic        w_wr_en;
  logic        w_rd_en;
  logic        w_full;
  logic [17:0] w_entry;
  logic [17:0] w_head;

  always_comb begin
    sop_pend_d   = sop_pend_q;
    eop_pend_d   = eop_pend_q;
    esc_pend_d   = esc_pend_q;
    chan_pend_d  = chan_pend_q;
    channel_d    = channel_q;
    w_wr_req     = 1'b0;
    w_literal    = esc_pend_q ? (in_data ^ 8'h20) : in_data;
    // An escaped byte is always literal, even when it decodes to a control value.
    w_is_literal = in_valid && (esc_pend_q ||
                   !(in_data inside {C_SOP_BYTE, C_EOP_BYTE, C_CHAN_BYTE, C_ESC_BYTE}));

    if (in_valid) begin
      if (esc_pend_q) begin
        esc_pend_d = 1'b0;
      end else begin
        case (in_data)
          C_ESC_BYTE:  esc_pend_d  = 1'b1;
          C_SOP_BYTE:  sop_pend_d  = 1'b1;
          C_EOP_BYTE:  eop_pend_d  = 1'b1;
          C_CHAN_BYTE: chan_pend_d = 1'b1;
          default: ;
        endcase
      end
    end

    if (w_is_literal) begin
      if (chan_pend_q) begin
        channel_d   = w_literal;
        chan_pend_d = 1'b0;
      end else begin
        // Marks are consumed even if the FIFO rejects the byte.
        w_wr_req   = 1'b1;
        sop_pend_d = 1'b0;
        eop_pend_d = 1'b0;
      end
    end

    w_full     = (level_q == C_DEPTH);
    w_wr_en    = w_wr_req && !w_full;
    overflow_d = w_wr_req && w_full;
    w_rd_en    = out_valid && out_ready;
    wr_ptr_d   = wr_ptr_q + FIFO_DEPTH_WIDTH'(w_wr_en);
    rd_ptr_d   = rd_ptr_q + FIFO_DEPTH_WIDTH'(w_rd_en);
    level_d    = level_q + (FIFO_DEPTH_WIDTH + 1)'(w_wr_en) - (FIFO_DEPTH_WIDTH + 1)'(w_rd_en);
    w_entry    = {sop_pend_q, eop_pend_q, channel_q, w_literal};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sop_pend_q  <= 1'b0;
      eop_pend_q  <= 1'b0;
      esc_pend_q  <= 1'b0;
      chan_pend_q <= 1'b0;
      channel_q   <= 8'h00;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      sop_pend_q  <= sop_pend_d;
      eop_pend_q  <= eop_pend_d;
      esc_pend_q  <= esc_pend_d;
      chan_pend_q <= chan_pend_d;
      channel_q   <= channel_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q] <= w_entry;
    end
  end

  assign w_head            = mem_q[rd_ptr_q];
  assign out_valid         = (level_q != '0);
  assign out_data          = out_valid ? w_head[7:0]  : 8'h00;
  assign out_channel       = out_valid ? w_head[15:8] : 8'h00;
  assign out_endofpacket   = out_valid && w_head[16];
  assign out_startofpacket = out_valid && w_head[17];
  assign overflow          = overflow_q;
  assign fifo_level        = level_q;

endmodule
`default_nettype wire

// File: tb/tb_peridot_rx_bytes2packets.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_peridot_rx_bytes2packets: directed and random stimulus checked        |
// | against a queue-based reference model.                  Revision: 1.0    |
// +--------------------------------------------------------------------------+
module tb_peridot_rx_bytes2packets;

  localparam int FIFO_DEPTH_WIDTH = 4;
  localparam int DEPTH            = 1 << FIFO_DEPTH_WIDTH;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      in_valid;
  logic [7:0]                in_data;
  logic                      out_ready;
  logic                      out_valid;
  logic [7:0]                out_data;
  logic [7:0]                out_channel;
  logic                      out_startofpacket;
  logic                      out_endofpacket;
  logic                      overflow;
  logic [FIFO_DEPTH_WIDTH:0] fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending marks, channel and a queue of {sop,eop,ch,data}.
  logic [17:0] m_q[$];
  bit          m_sop, m_eop, m_esc, m_chan, m_ovf;
  logic [7:0]  m_ch;

  peridot_rx_bytes2packets #(.FIFO_DEPTH_WIDTH(FIFO_DEPTH_WIDTH)) u_dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .overflow          (overflow),
    .fifo_level        (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sop = 0; m_eop = 0; m_esc = 0; m_chan = 0; m_ovf = 0;
    m_ch  = 8'h00;
  endtask

  // Called one time unit after a rising edge: check state, then advance model and DUT one cycle.
  task automatic step(input logic v, input logic [7:0] d, input logic rdy);
    bit         rd, full, is_lit;
    logic [7:0] lit;
    logic [17:0] head;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    #1;
    check("out_valid",  32'(out_valid),  32'(m_q.size() != 0));
    check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check("overflow",   32'(overflow),   32'(m_ovf));
    if (m_q.size() != 0) begin
      head = m_q[0];
      check("out_data", 32'(out_data),          32'(head[7:0]));
      check("out_chan", 32'(out_channel),       32'(head[15:8]));
      check("out_eop",  32'(out_endofpacket),   32'(head[16]));
      check("out_sop",  32'(out_startofpacket), 32'(head[17]));
    end

    full   = (m_q.size() == DEPTH);
    rd     = (m_q.size() != 0) && rdy;
    is_lit = 0;
    lit    = d;
    m_ovf  = 0;
    if (v) begin
      if (m_esc) begin
        m_esc = 0; is_lit = 1; lit = d ^ 8'h20;
      end else if (d == 8'h7D) m_esc  = 1;
      else if (d == 8'h7A)     m_sop  = 1;
      else if (d == 8'h7B)     m_eop  = 1;
      else if (d == 8'h7C)     m_chan = 1;
      else                     is_lit = 1;
    end
    if (rd) void'(m_q.pop_front());
    if (is_lit) begin
      if (m_chan) begin
        m_ch = lit; m_chan = 0;
      end else begin
        if (full) m_ovf = 1;
        else      m_q.push_back({m_sop, m_eop, m_ch, lit});
        m_sop = 0; m_eop = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic rdy);
    step(1'b1, d, rdy);
  endtask

  initial begin
    logic [7:0] seq1 [7] = '{8'h7A, 8'h7C, 8'h03, 8'h11, 8'h22, 8'h7B, 8'h33};
    logic [7:0] seq2 [8] = '{8'h7A, 8'h7D, 8'h5A, 8'h7D, 8'h5D, 8'h7B, 8'h7D, 8'h5B};
    logic [7:0] seq3 [6] = '{8'h7C, 8'h7D, 8'h5C, 8'h7A, 8'h7B, 8'h44};
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 32'(out_valid),         0);
    check("rst_level", 32'(fifo_level),        0);
    check("rst_ovf",   32'(overflow),          0);
    check("rst_data",  32'(out_data),          0);
    check("rst_chan",  32'(out_channel),       0);
    check("rst_sop",   32'(out_startofpacket), 0);
    check("rst_eop",   32'(out_endofpacket),   0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Framing: beat 11 must be at the head one cycle after it arrives.
    for (int i = 0; i < 4; i++) send(seq1[i], 1'b1);
    check("t1_data11", 32'(out_data), 32'h11);
    check("t1_sop11",  32'(out_startofpacket), 1);
    check("t1_ch03",   32'(out_channel), 32'h03);
    for (int i = 4; i < 7; i++) send(seq1[i], 1'b1);
    check("t1_data33", 32'(out_data), 32'h33);
    check("t1_eop33",  32'(out_endofpacket), 1);
    step(1'b0, 8'h00, 1'b1);

    // Escapes
    foreach (seq2[i]) send(seq2[i], 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("t2_level0", 32'(fifo_level), 0);

    // Escaped channel, single-byte packet
    foreach (seq3[i]) send(seq3[i], 1'b0);
    check("t3_data", 32'(out_data), 32'h44);
    check("t3_ch",   32'(out_channel), 32'h7C);
    check("t3_sop",  32'(out_startofpacket), 1);
    check("t3_eop",  32'(out_endofpacket), 1);
    step(1'b0, 8'h00, 1'b1);

    // Overflow on the 17th byte, then in-order drain
    for (int i = 0; i <= 16; i++) send(8'(i), 1'b0);
    check("t4_level16", 32'(fifo_level), 16);
    check("t4_ovf",     32'(overflow), 1);
    for (int i = 0; i < 16; i++) begin
      check("t4_drain", 32'(out_data), 32'(i));
      step(1'b0, 8'h00, 1'b1);
    end
    check("t4_empty", 32'(out_valid), 0);

    // Full with simultaneous read: write rejected, level drops by one
    for (int i = 0; i < 16; i++) send(8'(i + 8'h20), 1'b0);
    send(8'h55, 1'b1);
    check("t5_ovf",     32'(overflow), 1);
    check("t5_level15", 32'(fifo_level), 15);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);

    // Reset mid-operation
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    send(8'h7A, 1'b0);
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_level", 32'(fifo_level), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send(8'h66, 1'b0);
    check("t6_data", 32'(out_data), 32'h66);
    check("t6_sop",  32'(out_startofpacket), 0);
    check("t6_ch",   32'(out_channel), 0);
    step(1'b0, 8'h00, 1'b1);

    // Random traffic biased towards control bytes
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 3) b = 8'(8'h7A + $urandom_range(0, 3));
      step(1'($urandom_range(0, 9) < 7), b, 1'($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 8 : 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
